command_issuer: RTL and testbench
=================================

# command_issuer

Host-side transmitter for the 12-bit command/run interface consumed by the ALU controller. It buffers host commands in a small FIFO and issues them one at a time: it drives `command` stable, pulses `run` for one cycle, then waits for `done`. It captures the 32-bit result `y` and the O/C/Z/N flags, and presents them to the host through a valid/ready result port, with a timeout if the controller never answers.

## Interface
- `DEPTH`, 8: command FIFO entries, power of two, at least 2.
- `TIMEOUT`, 15: maximum cycles spent in WAIT before the command is abandoned; range 1..255.
- `clk` in 1: the single clock; everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: host offers `cmd_data`.
- `cmd_ready` out 1: equals `count < DEPTH`.
- `cmd_data` in 12: command word; the issuer treats it as opaque.
- `command` out 12: command presented to the controller.
- `run` out 1: one-cycle issue strobe to the controller.
- `done` in 1: controller completion strobe.
- `y` in 32: controller/ALU result.
- `flags` in 4: {O,C,Z,N}.
- `res_valid` out 1: result held for the host.
- `res_ready` in 1: host accepts the result.
- `res_data` out 32: captured `y`, or 0 on timeout.
- `res_flags` out 4: captured flags, or 0 on timeout.
- `res_timeout` out 1: set when the result came from a timeout.
- `busy` out 1: high whenever the state is not IDLE.
- `count` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and HOLD.
- **IDLE.** If `count != 0`, pop the FIFO head into the `command` register and go to ISSUE. Otherwise stay in IDLE.
- **ISSUE.** Lasts exactly one cycle. `run = 1`; `done` is ignored in this state. The timeout counter is cleared, then the FSM goes to WAIT.
- **WAIT.** `command` is held. The timeout counter increments once per WAIT cycle.
  - If `done` is high: capture `y` into `res_data` and `flags` into `res_flags`, clear `res_timeout`, and go to HOLD.
  - Otherwise, when the counter reaches `TIMEOUT`: set `res_data = 0`, `res_flags = 0`, `res_timeout = 1`, and go to HOLD.
  - If `done` arrives in the same cycle the timeout would fire, `done` wins.
- **HOLD.** `res_valid = 1` and all `res_*` outputs are stable. If `res_ready` is high, go to IDLE. `command` keeps its last value.
- **FIFO push.** A push happens when `cmd_valid && cmd_ready`.
  - A push while full is refused, even if a pop happens in the same cycle.
  - A simultaneous push and pop with `count` between 1 and DEPTH-1 leaves `count` unchanged.
  - The read and write pointers wrap modulo DEPTH.
- **FIFO pop.** Pops happen only on the IDLE→ISSUE transition, so the FIFO is never read while empty.
- `run` is a registered output and is never high for two consecutive cycles.
- Exactly one command is outstanding at a time.
- **Reset values:**
  - FSM in IDLE, FIFO empty, `count = 0`, `cmd_ready = 1`.
  - `command = 0`, `run = 0`, `res_valid = 0`, `res_data = 0`, `res_flags = 0`, `res_timeout = 0`, `busy = 0`.
- **Reset mid-operation** (in any state) abandons the outstanding command and discards the FIFO contents. `run` and `res_valid` are low in the first cycle after the reset edge.

## Timing
- A command accepted at edge 0 into an empty FIFO, while IDLE, drives `command` and `run = 1` during the cycle after edge 1.
- `done` is first sampled at edge 3, one cycle after the `run` cycle.
- A `done` sampled at edge n gives `res_valid = 1` from edge n.
- Best-case issue-to-result is 2 edges after the start of `run`.
- A timeout gives `res_valid` at edge 2 + `TIMEOUT`, counted from the ISSUE edge.
- A HOLD handshake at edge m returns the FSM to IDLE at m. The next queued command then shows `run` after edge m+1. The per-command overhead is 1 IDLE cycle plus 1 ISSUE cycle.
- `cmd_ready` reflects registered `count`; there is no combinational path from `cmd_valid` to `cmd_ready`.

## Structure
- The package `alu_cmd_pkg` holds:
  - `CMD_W = 12`, `DATA_W = 32`, `FLAG_W = 4`;
  - the flag indices `FLAG_O = 3`, `FLAG_C = 2`, `FLAG_Z = 1`, `FLAG_N = 0`;
  - the typedef `issuer_state_t` enum {IDLE, ISSUE, WAIT, HOLD}.
- Sub-module `cmd_fifo` is a synchronous FIFO parameterised by width and depth, with push/pop, full/empty and count. The FSM, timeout counter and result registers stay in the top module.

## Test plan
- **Single command.** Push 0x1A5. Expect `command = 0x1A5` and a single `run` pulse. Drive `done` 2 cycles later with `y = 0xDEADBEEF`, `flags = 4'b0010`. Expect `res_valid` with those values and `res_timeout = 0`. Hold `res_ready` low for 5 cycles and confirm the result outputs stay stable.
- **Full FIFO.** Push 9 commands back-to-back with DEPTH = 8 while the FSM is stuck in WAIT.
  - Expect `cmd_ready` to drop after 8 accepts and the 9th to be refused.
  - Then complete each command: the 8 commands must come out in order with 8 `run` pulses, and `count` must return to 0.
- **Timeout.** With `TIMEOUT = 15` and `done` held low, expect `res_valid`, `res_timeout = 1` and `res_data = 0` exactly 17 edges after the ISSUE edge. Repeat with `done` asserted on the final WAIT cycle: expect a normal result.
- **Done during ISSUE.** Hold `done = 1` during the ISSUE cycle only. The FSM must ignore it and stay in WAIT.
- **Pointer wrap.** Run 20 push/pop interleavings with simultaneous push and pop at `count = 3`. Check that `count` stays at 3 and that data order is preserved across the DEPTH wrap.
- **Reset mid-operation.** Assert `rst` for 1 cycle in WAIT with 4 commands queued. Expect every output at its reset value and `count = 0`. The next push must issue normally.

Source files
------------

// File: rtl/alu_cmd_pkg.sv
// Shared widths, flag bit positions and issuer FSM encoding for the
// command/run interface between the host issuer and the ALU controller.
package alu_cmd_pkg;

  localparam int CMD_W  = 12;
  localparam int DATA_W = 32;
  localparam int FLAG_W = 4;

  localparam int FLAG_O = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } issuer_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered occupancy count; pushes while full and
// pops while empty are ignored so the caller can drive raw requests.
module cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/command_issuer.sv
// Host-side issuer: queues commands, strobes run, waits for done or timeout,
// and holds the captured result on a valid/ready port until the host takes it.
module command_issuer
  import alu_cmd_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [CMD_W-1:0]       cmd_data,
  output logic [CMD_W-1:0]       command,
  output logic                   run,
  input  logic                   done,
  input  logic [DATA_W-1:0]      y,
  input  logic [FLAG_W-1:0]      flags,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_data,
  output logic [FLAG_W-1:0]      res_flags,
  output logic                   res_timeout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam logic [7:0] TMO_CNT = 8'(TIMEOUT);

  issuer_state_t    state;
  issuer_state_t    state_n;
  logic [7:0]       tcnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_head;
  logic             tcnt_clr;
  logic             tcnt_inc;
  logic             cap_done;
  logic             cap_tmo;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .wdata (cmd_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign cmd_ready = !fifo_full;
  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    tcnt_clr = 1'b0;
    tcnt_inc = 1'b0;
    cap_done = 1'b0;
    cap_tmo  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_clr = 1'b1;
        state_n  = WAIT;
      end
      WAIT: begin
        // done is checked first so a completion on the last WAIT cycle wins
        if (done) begin
          cap_done = 1'b1;
          state_n  = HOLD;
        end else if (tcnt == TMO_CNT) begin
          cap_tmo = 1'b1;
          state_n = HOLD;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      HOLD: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control stage: state, run strobe and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      run   <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_n;
      run   <= fifo_pop;
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + 1'b1;
    end
  end

  // Capture stage: command and result registers have defined reset values
  always_ff @(posedge clk) begin
    if (rst) begin
      command     <= '0;
      res_data    <= '0;
      res_flags   <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (fifo_pop) command <= fifo_head;
      if (cap_done) begin
        res_data    <= y;
        res_flags   <= flags;
        res_timeout <= 1'b0;
      end else if (cap_tmo) begin
        res_data    <= '0;
        res_flags   <= '0;
        res_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_command_issuer.sv
// Scoreboard bench for command_issuer: a host driver, a controller responder
// and a monitor that checks issued commands, result latency and contents.
module tb_command_issuer;
  import alu_cmd_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CMD_W-1:0]  cmd_data = '0;
  logic [CMD_W-1:0]  command;
  logic              run;
  logic              done = 1'b0;
  logic [DATA_W-1:0] y = '0;
  logic [FLAG_W-1:0] flags = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [DATA_W-1:0] res_data;
  logic [FLAG_W-1:0] res_flags;
  logic              res_timeout;
  logic              busy;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  command_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .command(command), .run(run), .done(done), .y(y),
    .flags(flags), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags), .res_timeout(res_timeout),
    .busy(busy), .count(count)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flg;
    logic              tmo;
    int                lat;
  } res_t;

  res_t             res_q[$];
  logic [CMD_W-1:0] exp_cmd_q[$];
  logic [CMD_W-1:0] stim_q[$];

  int vectors = 0;
  int miscompares = 0;

  int push_pct = 0;
  bit stim_drop = 0;
  bit wrap_mode = 0;
  int wrap_pushes = 0;
  int refused = 0;
  int k_mode = -1;
  int ready_pct = 100;
  bit fixed_en = 0;
  int occ = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_command"}, command, 0);
    check({nm, "_run"}, run, 0);
    check({nm, "_res_valid"}, res_valid, 0);
    check({nm, "_res_data"}, res_data, 0);
    check({nm, "_res_flags"}, res_flags, 0);
    check({nm, "_res_timeout"}, res_timeout, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_count"}, count, 0);
    check({nm, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(stim_q.size() == 0 && occ == 0 && count == 0 && !busy &&
                 res_q.size() == 0 && !cmd_valid) && n < budget);
    check({nm, "_drained"}, n < budget, 1);
  endtask

  // Offer one word; the model's occupancy alone decides whether it is taken
  task automatic offer(input logic [CMD_W-1:0] d, output bit acc);
    cmd_valid = 1'b1;
    cmd_data  = d;
    acc = (occ < DEPTH);
    if (acc) exp_cmd_q.push_back(d);
    else     refused++;
  endtask

  initial begin : driver
    bit pushed;
    bit acc;
    pushed = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        occ = 0;
        pushed = 0;
        cmd_valid = 1'b0;
        exp_cmd_q.delete();
      end else begin
        if (pushed) occ++;
        if (run)    occ--;
        check("count", count, occ);
        check("cmd_ready", cmd_ready, occ < DEPTH);
        pushed = 0;
        cmd_valid = 1'b0;
        if (wrap_mode) begin
          if (!busy && occ > 0 && wrap_pushes > 0) begin
            offer(12'($urandom), acc);
            pushed = acc;
            wrap_pushes--;
          end
        end else if (stim_q.size() > 0) begin
          offer(stim_q[0], acc);
          pushed = acc;
          if (acc || stim_drop) void'(stim_q.pop_front());
        end else if ($urandom_range(99) < push_pct) begin
          offer(12'($urandom), acc);
          pushed = acc;
        end
      end
    end
  end

  // Controller model: done at the k-th WAIT sample completes iff 1 <= k <= TIMEOUT+1
  initial begin : responder
    int kcnt;
    int k;
    int sel;
    res_t r;
    logic [DATA_W-1:0] pend_y;
    logic [FLAG_W-1:0] pend_f;
    kcnt = 0;
    pend_y = '0;
    pend_f = '0;
    forever begin
      @(negedge clk);
      done  = 1'b0;
      y     = $urandom;
      flags = 4'($urandom_range(15));
      if (rst) begin
        kcnt = 0;
        res_q.delete();
      end else begin
        if (kcnt > 0) begin
          kcnt--;
          if (kcnt == 0) begin
            done = 1'b1;
            y = pend_y;
            flags = pend_f;
          end
        end
        if (run) begin
          if (k_mode >= 0) k = k_mode;
          else begin
            sel = $urandom_range(9);
            if (sel <= 5)      k = 1 + $urandom_range(3);
            else if (sel == 6) k = 0;
            else if (sel == 7) k = TIMEOUT;
            else if (sel == 8) k = TIMEOUT + 1;
            else               k = TIMEOUT + 2 + $urandom_range(2);
          end
          if (k >= 1 && k <= TIMEOUT + 1) begin
            pend_y = fixed_en ? 32'hDEADBEEF : $urandom;
            pend_f = fixed_en ? 4'b0010 : 4'($urandom_range(15));
            r.data = pend_y;
            r.flg  = pend_f;
            r.tmo  = 1'b0;
            r.lat  = k + 1;
            kcnt   = k;
          end else begin
            r.data = '0;
            r.flg  = '0;
            r.tmo  = 1'b1;
            r.lat  = TIMEOUT + 2;
            if (k == 0) done = 1'b1;
          end
          res_q.push_back(r);
        end
      end
    end
  end

  initial begin : host_ready
    forever begin
      @(posedge clk); #1;
      res_ready = ($urandom_range(99) < ready_pct);
    end
  end

  initial begin : monitor
    bit run_prev;
    bit waiting;
    int lat;
    res_t r;
    logic [CMD_W-1:0] last_cmd;
    run_prev = 0;
    waiting = 0;
    lat = 0;
    last_cmd = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        run_prev = 0;
        waiting = 0;
      end else begin
        if (run) begin
          check("run_gap", run_prev, 0);
          if (exp_cmd_q.size() == 0) check("unexpected_run", run, 0);
          else check("command", command, exp_cmd_q.pop_front());
          last_cmd = command;
          waiting = 1;
          lat = 0;
        end else begin
          if (waiting) lat++;
          if (busy) check("command_hold", command, last_cmd);
        end
        if (res_valid) begin
          if (res_q.size() == 0) check("unexpected_result", res_valid, 0);
          else begin
            r = res_q[0];
            if (waiting) begin
              check("latency", lat, r.lat);
              waiting = 0;
            end
            check("res_data", res_data, r.data);
            check("res_flags", res_flags, r.flg);
            check("res_timeout", res_timeout, r.tmo);
            if (res_ready) void'(res_q.pop_front());
          end
        end
        run_prev = run;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    #1 rst = 1'b0;

    // Single command with a held result
    ready_pct = 0;
    k_mode = 2;
    fixed_en = 1;
    stim_q.push_back(12'h1A5);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!res_valid && n < 50);
    check("single_valid", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("single_hold_valid", res_valid, 1);
      check("single_data", res_data, 32'hDEADBEEF);
      check("single_flags", res_flags, 4'b0010);
      check("single_timeout", res_timeout, 0);
      check("single_command", command, 12'h1A5);
      @(posedge clk); #1;
    end
    #1 ready_pct = 100;
    fixed_en = 0;
    wait_idle("single", 100);

    // Fill the FIFO while the controller stalls
    #1 k_mode = TIMEOUT + 5;
    stim_q.push_back(12'h100);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!busy && n < 20);
    check("full_busy", busy, 1);
    #1 stim_drop = 1;
    for (int i = 0; i < 9; i++) stim_q.push_back(12'h200 + 12'(i));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (stim_q.size() != 0 && n < 30);
    check("full_count", count, DEPTH);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_refused", refused, 1);
    #1 stim_drop = 0;
    k_mode = -1;
    wait_idle("full", 2000);

    // Timeout, done on the last WAIT cycle, and done during ISSUE
    #1 k_mode = TIMEOUT + 2;
    stim_q.push_back(12'($urandom));
    wait_idle("timeout", 200);
    #1 k_mode = TIMEOUT + 1;
    stim_q.push_back(12'($urandom));
    wait_idle("late_done", 200);
    #1 k_mode = 0;
    stim_q.push_back(12'($urandom));
    wait_idle("issue_done", 200);

    // Simultaneous push/pop at count 3 across the pointer wrap
    #1 k_mode = 1;
    ready_pct = 0;
    for (int i = 0; i < 4; i++) stim_q.push_back(12'h400 + 12'(i));
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!(occ == 3 && stim_q.size() == 0 && res_valid) && n < 50);
    check("wrap_start", count, 3);
    #1 wrap_pushes = 20;
    wrap_mode = 1;
    ready_pct = 100;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (wrap_pushes != 0) check("wrap_count", count, 3);
    end while (wrap_pushes != 0 && n < 500);
    check("wrap_end", count, 3);
    #1 wrap_mode = 0;
    wait_idle("wrap", 500);

    // Reset while waiting with four commands queued
    #1 k_mode = TIMEOUT + 5;
    for (int i = 0; i < 5; i++) stim_q.push_back(12'h500 + 12'(i));
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!(occ == 4 && stim_q.size() == 0 && busy) && n < 50);
    check("mid_queued", count, 4);
    #1 rst = 1'b1;
    @(posedge clk); #1 check_reset("mid_reset");
    #1 rst = 1'b0;
    k_mode = 1;
    stim_q.push_back(12'h3C3);
    wait_idle("post_reset", 200);

    // Randomised traffic
    #1 push_pct = 40;
    k_mode = -1;
    ready_pct = 60;
    repeat (3000) @(posedge clk);
    #2 push_pct = 0;
    wait_idle("random", 3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
